uart_core: RTL and testbench
============================

Name: uart_core

Overview:
- Full-duplex 8N1 UART: one transmitter and one receiver sharing a single clock domain.
- Transmitter serialises a byte on request. Receiver deserialises the incoming line and presents each byte with a one-cycle valid strobe.
- Sits between a byte-level host interface and the external serial pins.
- Baud rate is set by a clocks-per-bit parameter: 10 MHz / 115200 gives 87.

Parameters:
- CLKS_PER_BIT, 87, number of i_Clock cycles per serial bit. Legal range is 8 or more.

Ports:
- i_Clock  input  1  system clock, rising edge.
- i_Rst_n  input  1  reset, asynchronous, active-low.
- i_Tx_DV  input  1  transmit request; sampled only while the transmitter is idle.
- i_Tx_Byte  input  8  byte to transmit; latched on an accepted i_Tx_DV.
- o_Tx_Active  output  1  high while a frame is being transmitted.
- o_Tx_Serial  output  1  serial line out; idles high.
- o_Tx_Done  output  1  one-cycle pulse when a frame completes.
- i_Rx_Serial  input  1  serial line in; asynchronous to i_Clock; idles high.
- o_Rx_DV  output  1  one-cycle pulse when a valid byte has been received.
- o_Rx_Byte  output  8  last received byte; held until the next valid byte.
- o_Rx_Frame_Err  output  1  one-cycle pulse when the stop bit is sampled low.

Behaviour:
- Reset (asynchronous, i_Rst_n=0):
  - Both FSMs go to IDLE; all counters clear.
  - Outputs: o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Rx_DV=0, o_Rx_Byte=0, o_Rx_Frame_Err=0.
  - Reset mid-frame aborts the frame; no Done or DV pulse is generated for it.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
- TX FSM states: IDLE, START, DATA, STOP, CLEANUP.
  - IDLE: o_Tx_Serial=1. On the rising edge where i_Tx_DV=1:
    - latch i_Tx_Byte;
    - o_Tx_Active goes to 1;
    - o_Tx_Serial goes to 0 from that edge;
    - move to START.
  - START, each DATA bit and STOP each last exactly CLKS_PER_BIT cycles, using a bit-cycle counter and a 3-bit bit index.
  - At the end of STOP: o_Tx_Active=0 and o_Tx_Done=1 for exactly one cycle; move to CLEANUP.
  - CLEANUP lasts one cycle, then IDLE. A new request is accepted in IDLE, so back-to-back frames have a 1-cycle gap.
  - i_Tx_DV is ignored in any state other than IDLE; the latched byte is immune to i_Tx_Byte changes mid-frame.
- RX input conditioning: i_Rx_Serial passes through a 2-flop synchroniser (reset value 1). Internal timing below is referenced to the synchronised signal.
- RX FSM states: IDLE, START, DATA, STOP, CLEANUP.
  - IDLE: a synchronised low moves the FSM to START.
  - START: count to (CLKS_PER_BIT-1)/2, the mid-bit point.
    - If the line is still low, clear the counter and go to DATA.
    - Otherwise treat it as a glitch and return to IDLE, with no outputs.
  - DATA: every CLKS_PER_BIT cycles sample one bit into the shift register (LSB first); after 8 bits go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample the line.
    - If 1: update o_Rx_Byte with the shift register and pulse o_Rx_DV for one cycle.
    - If 0: pulse o_Rx_Frame_Err for one cycle; o_Rx_Byte keeps its old value.
  - CLEANUP: one cycle, then IDLE. The receiver re-arms before the stop bit ends, so back-to-back frames are received.
- Mid-bit sampling tolerates a start bit stretched or bits skewed by up to ±40% of a bit period. Example: a start bit lengthened by 10 clocks at CLKS_PER_BIT=87 must still decode correctly.
- TX and RX are fully independent and may operate simultaneously.

Test Plan:
- CLKS_PER_BIT=87, 100 ns clock; pulse i_Tx_DV for 1 cycle with 0xAB.
  - o_Tx_Serial sequence: 0,1,1,0,1,0,1,0,1,1, each level held 87 cycles.
  - o_Tx_Active high for 870 cycles; o_Tx_Done single pulse at the end.
- Drive 0x3F on i_Rx_Serial at 8600 ns per bit, with the start bit extended by 1000 ns -> single o_Rx_DV pulse; o_Rx_Byte=0x3F; o_Rx_Frame_Err stays 0.
- Loop o_Tx_Serial to i_Rx_Serial; send 0x00, 0xFF, 0x55 back-to-back (re-assert i_Tx_DV after each o_Tx_Done) -> three o_Rx_DV pulses with bytes 0x00, 0xFF, 0x55 in order.
- 20-cycle low glitch on i_Rx_Serial while idle -> no o_Rx_DV, no o_Rx_Frame_Err; next valid frame 0xA5 received correctly.
- Frame 0x12 with stop bit driven 0 -> o_Rx_Frame_Err pulse; no o_Rx_DV; o_Rx_Byte unchanged.
- Assert i_Rst_n=0 mid-TX and mid-RX frame -> outputs immediately return to reset values; no Done or DV pulse; the next frame after release works normally.

Source files
------------

// File: rtl/uart_core.sv
// Full-duplex 8N1 UART: independent transmitter and receiver in one clock domain.
// Bit timing is set by CLKS_PER_BIT. The receiver samples each bit at its midpoint.
`timescale 1ns/1ps
module uart_core #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Active,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Done,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Frame_Err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_CLEANUP = 3'd4
  } state_e;

  // ---------------- Transmitter ----------------
  state_e           tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_idx_q, tx_idx_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             tx_serial_q, tx_serial_d;
  logic             tx_active_q, tx_active_d;
  logic             tx_done_q, tx_done_d;

  // TX state and output registers
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      tx_state_q  <= ST_IDLE;
      tx_cnt_q    <= '0;
      tx_idx_q    <= 3'd0;
      tx_byte_q   <= 8'h00;
      tx_serial_q <= 1'b1;
      tx_active_q <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_idx_q    <= tx_idx_d;
      tx_byte_q   <= tx_byte_d;
      tx_serial_q <= tx_serial_d;
      tx_active_q <= tx_active_d;
      tx_done_q   <= tx_done_d;
    end
  end

  // TX next-state: the serial level for each bit is registered, so it changes on the bit boundary edge
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_idx_d    = tx_idx_q;
    tx_byte_d   = tx_byte_q;
    tx_serial_d = tx_serial_q;
    tx_active_d = tx_active_q;
    tx_done_d   = 1'b0;
    case (tx_state_q)
      ST_IDLE: begin
        tx_cnt_d    = '0;
        tx_idx_d    = 3'd0;
        if (i_Tx_DV) begin
          tx_byte_d   = i_Tx_Byte;
          tx_serial_d = 1'b0;
          tx_active_d = 1'b1;
          tx_state_d  = ST_START;
        end else begin
          tx_serial_d = 1'b1;
          tx_active_d = 1'b0;
        end
      end
      ST_START: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d    = '0;
          tx_serial_d = tx_byte_q[0];
          tx_state_d  = ST_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d = '0;
          if (tx_idx_q == 3'd7) begin
            tx_idx_d    = 3'd0;
            tx_serial_d = 1'b1;
            tx_state_d  = ST_STOP;
          end else begin
            tx_idx_d    = tx_idx_q + 3'd1;
            tx_serial_d = tx_byte_q[tx_idx_q + 3'd1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d    = '0;
          tx_active_d = 1'b0;
          tx_done_d   = 1'b1;
          tx_state_d  = ST_CLEANUP;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      ST_CLEANUP: begin
        tx_state_d = ST_IDLE;
      end
      default: begin
        tx_state_d  = ST_IDLE;
        tx_serial_d = 1'b1;
        tx_active_d = 1'b0;
      end
    endcase
  end

  // ---------------- Receiver ----------------
  logic             rx_sync1_q, rx_sync2_q;
  state_e           rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_idx_q, rx_idx_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             rx_dv_q, rx_dv_d;
  logic             rx_err_q, rx_err_d;

  // Two-flop synchroniser for the asynchronous serial input
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
    end else begin
      rx_sync1_q <= i_Rx_Serial;
      rx_sync2_q <= rx_sync1_q;
    end
  end

  // RX state and output registers
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_byte_q  <= 8'h00;
      rx_dv_q    <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_byte_q  <= rx_byte_d;
      rx_dv_q    <= rx_dv_d;
      rx_err_q   <= rx_err_d;
    end
  end

  // RX next-state: after the mid-start check every later sample lands mid-bit
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_byte_d  = rx_byte_q;
    rx_dv_d    = 1'b0;
    rx_err_d   = 1'b0;
    case (rx_state_q)
      ST_IDLE: begin
        rx_cnt_d = '0;
        rx_idx_d = 3'd0;
        if (!rx_sync2_q) begin
          rx_state_d = ST_START;
        end else begin
          rx_state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (rx_cnt_q == CNT_MID) begin
          rx_cnt_d = '0;
          if (!rx_sync2_q) begin
            rx_state_d = ST_DATA;
          end else begin
            rx_state_d = ST_IDLE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d             = '0;
          rx_shift_d[rx_idx_q] = rx_sync2_q;
          if (rx_idx_q == 3'd7) begin
            rx_idx_d   = 3'd0;
            rx_state_d = ST_STOP;
          end else begin
            rx_idx_d = rx_idx_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = ST_CLEANUP;
          if (rx_sync2_q) begin
            rx_byte_d = rx_shift_q;
            rx_dv_d   = 1'b1;
          end else begin
            rx_err_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      ST_CLEANUP: begin
        rx_state_d = ST_IDLE;
      end
      default: begin
        rx_state_d = ST_IDLE;
      end
    endcase
  end

  assign o_Tx_Serial    = tx_serial_q;
  assign o_Tx_Active    = tx_active_q;
  assign o_Tx_Done      = tx_done_q;
  assign o_Rx_DV        = rx_dv_q;
  assign o_Rx_Byte      = rx_byte_q;
  assign o_Rx_Frame_Err = rx_err_q;

endmodule

// File: tb/tb_uart_core.sv
// Directed self-checking bench for uart_core: TX waveform, RX decode, loopback,
// glitch rejection, framing error and mid-frame reset.
`timescale 1ns/1ps
module tb_uart_core;
  localparam int CPB = 87;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_dv = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_active, tx_serial, tx_done;
  logic       rx_drv = 1'b1;
  logic       loop_en = 1'b0;
  logic       rx_line;
  logic       rx_dv, rx_err;
  logic [7:0] rx_byte;

  int checks = 0;
  int failures = 0;
  int rx_dv_cnt = 0;
  int rx_err_cnt = 0;
  int tx_done_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  assign rx_line = loop_en ? tx_serial : rx_drv;

  uart_core #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock(clk), .i_Rst_n(rst_n),
    .i_Tx_DV(tx_dv), .i_Tx_Byte(tx_byte),
    .o_Tx_Active(tx_active), .o_Tx_Serial(tx_serial), .o_Tx_Done(tx_done),
    .i_Rx_Serial(rx_line), .o_Rx_DV(rx_dv), .o_Rx_Byte(rx_byte),
    .o_Rx_Frame_Err(rx_err)
  );

  always #50 clk = ~clk;

  // Output monitor: counts pulses and captures received bytes
  initial begin
    forever begin
      @(negedge clk);
      if (rx_dv) begin
        got_q.push_back(rx_byte);
        rx_dv_cnt++;
      end
      if (rx_err) rx_err_cnt++;
      if (tx_done) tx_done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_drain(input string tag);
    logic [7:0] e, g;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      chk({tag, "_byte"}, g, e);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic send_tx(input logic [7:0] b);
    int n;
    @(negedge clk);
    tx_dv = 1'b1;
    tx_byte = b;
    @(negedge clk);
    tx_dv = 1'b0;
    tx_byte = ~b;
    n = 0;
    while (!tx_done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("tx_done_timeout", 32'd0, 32'd1);
    @(posedge clk);
  endtask

  task automatic drive_rx(input logic [7:0] b, input int extra_ns, input int bit_ns, input logic stop_bit);
    rx_drv = 1'b0;
    #(bit_ns + extra_ns);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      #(bit_ns);
    end
    rx_drv = stop_bit;
    #(bit_ns);
    rx_drv = 1'b1;
  endtask

  initial begin
    logic [9:0] frame;
    int ser_bad, act_bad, done_in;
    int dv0, err0, done0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx_serial", tx_serial, 1'b1);
    chk("rst_tx_active", tx_active, 1'b0);
    chk("rst_tx_done", tx_done, 1'b0);
    chk("rst_rx_dv", rx_dv, 1'b0);
    chk("rst_rx_byte", rx_byte, 8'h00);
    chk("rst_rx_err", rx_err, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // TX waveform for 0xAB
    frame = {1'b1, 8'hAB, 1'b0};
    done0 = tx_done_cnt;
    tx_dv = 1'b1;
    tx_byte = 8'hAB;
    @(posedge clk);
    ser_bad = 0; act_bad = 0; done_in = 0;
    for (int n = 0; n < 10 * CPB; n++) begin
      @(negedge clk);
      if (n == 0) begin
        tx_dv = 1'b0;
        tx_byte = 8'h00;
      end
      if (tx_serial !== frame[n / CPB]) ser_bad++;
      if (tx_active !== 1'b1) act_bad++;
      if (tx_done !== 1'b0) done_in++;
      @(posedge clk);
    end
    chk("tx_serial_levels", ser_bad, 0);
    chk("tx_active_870", act_bad, 0);
    chk("tx_done_early", done_in, 0);
    @(negedge clk);
    chk("tx_done_pulse", tx_done, 1'b1);
    chk("tx_active_end", tx_active, 1'b0);
    @(negedge clk);
    chk("tx_done_clear", tx_done, 1'b0);
    chk("tx_done_count", tx_done_cnt - done0, 1);

    // RX 0x3F with stretched start, 86-clock bits
    repeat (20) @(negedge clk);
    err0 = rx_err_cnt;
    exp_q.push_back(8'h3F);
    drive_rx(8'h3F, 1000, 8600, 1'b1);
    repeat (200) @(negedge clk);
    sb_drain("rx_stretch");
    chk("rx_stretch_byte", rx_byte, 8'h3F);
    chk("rx_stretch_err", rx_err_cnt - err0, 0);

    // Loopback, back-to-back frames
    loop_en = 1'b1;
    repeat (10) @(negedge clk);
    exp_q.push_back(8'h00); send_tx(8'h00);
    exp_q.push_back(8'hFF); send_tx(8'hFF);
    exp_q.push_back(8'h55); send_tx(8'h55);
    repeat (200) @(negedge clk);
    sb_drain("loop");
    loop_en = 1'b0;

    // Glitch while idle, then a valid frame
    repeat (20) @(negedge clk);
    dv0 = rx_dv_cnt; err0 = rx_err_cnt;
    rx_drv = 1'b0;
    repeat (20) @(negedge clk);
    rx_drv = 1'b1;
    repeat (200) @(negedge clk);
    chk("glitch_dv", rx_dv_cnt - dv0, 0);
    chk("glitch_err", rx_err_cnt - err0, 0);
    exp_q.push_back(8'hA5);
    drive_rx(8'hA5, 0, 8700, 1'b1);
    repeat (200) @(negedge clk);
    sb_drain("post_glitch");

    // Framing error
    dv0 = rx_dv_cnt; err0 = rx_err_cnt;
    drive_rx(8'h12, 0, 8700, 1'b0);
    repeat (200) @(negedge clk);
    chk("ferr_pulse", rx_err_cnt - err0, 1);
    chk("ferr_no_dv", rx_dv_cnt - dv0, 0);
    chk("ferr_byte_held", rx_byte, 8'hA5);

    // Reset mid-TX and mid-RX
    dv0 = rx_dv_cnt; err0 = rx_err_cnt; done0 = tx_done_cnt;
    @(negedge clk);
    tx_dv = 1'b1;
    tx_byte = 8'hC3;
    rx_drv = 1'b0;
    @(negedge clk);
    tx_dv = 1'b0;
    repeat (300) @(negedge clk);
    chk("pre_rst_active", tx_active, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx_serial", tx_serial, 1'b1);
    chk("mid_rst_tx_active", tx_active, 1'b0);
    chk("mid_rst_tx_done", tx_done, 1'b0);
    chk("mid_rst_rx_dv", rx_dv, 1'b0);
    chk("mid_rst_rx_byte", rx_byte, 8'h00);
    chk("mid_rst_rx_err", rx_err, 1'b0);
    rx_drv = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (1200) @(negedge clk);
    chk("abort_no_done", tx_done_cnt - done0, 0);
    chk("abort_no_dv", rx_dv_cnt - dv0, 0);
    chk("abort_no_err", rx_err_cnt - err0, 0);

    // Normal frame after reset release
    loop_en = 1'b1;
    repeat (10) @(negedge clk);
    exp_q.push_back(8'h5A);
    send_tx(8'h5A);
    repeat (200) @(negedge clk);
    sb_drain("post_rst");
    chk("post_rst_done", tx_done_cnt - done0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
